bfloat16_div: RTL
=================

# bfloat16_div

Iterative, multi-cycle bfloat16 divider computing `a / b`; it is the inverse operation of the NPU's combinational bfloat16 multiplier. It uses the same field layout: sign[15], exponent[14:7] with bias 127, mantissa[6:0] with a hidden 1. It sits beside the multiplier in the NPU datapath. A controller drives it with a start/done handshake, and it produces one quotient bit per cycle using restoring division.

## Interface
- No parameters; the format is fixed to bfloat16.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `start`  in  1  — request; sampled only in IDLE.
- `a`  in  16  — dividend; captured on the accepting edge.
- `b`  in  16  — divisor; captured on the accepting edge.
- `busy`  out  1  — high while an operation is in flight.
- `done`  out  1  — one-cycle pulse when `result` becomes valid.
- `result`  out  16  — quotient; holds its value until the next `done`.
- `dz`  out  1  — divide-by-zero flag; updated together with `result`.

## Operation
- FSM states: IDLE → DIV (9 cycles) → NORM (1 cycle) → IDLE.
- **IDLE**: when `start`=1, latch the following, clear the bit counter, and enter DIV.
  - sign `s = a[15]^b[15]`
  - `ma = {1,a[6:0]}`, `mb = {1,b[6:0]}`
  - signed 10-bit `e = a[14:7] − b[14:7] + 127`
  - zero flags `za = (a[14:7]==0)`, `zb = (b[14:7]==0)`
- **DIV**: restoring division.
  - 10-bit remainder `R` initialised to `ma`.
  - Each cycle: if `R ≥ mb`, set `q` bit to 1 and `R = R − mb`, else set it to 0. Then `R = R << 1`.
  - Bits are generated MSB first, `q[8]` down to `q[0]`.
  - Result: `q = floor(ma·256 / mb)`, which always lies in 128..511.
- **NORM**: normalise and apply special cases.
  - If `q[8]=1`: `mant = q[7:1]`, `ef = e`.
  - Otherwise: `mant = q[6:0]`, `ef = e − 1`.
  - Truncate; there is no rounding.
  - Apply the first matching case, in priority order:
    1. `zb`: `result = {s,8'hFF,7'h00}`, `dz = 1`. This applies even when `a` is also zero.
    2. `za`: `result = {s,15'h0}`.
    3. `ef ≥ 255`: saturate to `{s,8'hFF,7'h00}`.
    4. `ef ≤ 0`: flush to `{s,15'h0}`.
    5. Otherwise: `result = {s,ef[7:0],mant}`.
  - `dz = 0` in every case except 1.
- Exponent field 0 is treated as zero; subnormals are not supported.
- Exponent field 255 is treated as an ordinary exponent; there is no NaN/Inf input handling.
- `start` is ignored while `busy` is high. Operands may change freely after the accepting edge.

## Timing
- Reset values: `busy=0`, `done=0`, `result=16'h0000`, `dz=0`, state IDLE, all internal registers 0.
- Acceptance: `start` high at edge k in IDLE.
  - `busy` goes high after edge k.
  - Edges k+1..k+9 produce `q[8]..q[0]`.
  - Edge k+10 (NORM) writes `result`/`dz`, sets `done=1` and `busy=0`, and returns to IDLE.
- Latency is exactly 10 cycles from the accepting edge to `done`. This is fixed for all operands, including the special cases.
- `done` is high for exactly one cycle.
- `start` during the `done` cycle is accepted at the next edge, giving a back-to-back issue interval of 11 cycles.
- `busy` and `done` are never high simultaneously.
- Reset asserted mid-operation aborts immediately: outputs go to their reset values, no `done` is produced, and the next `start` after reset deasserts proceeds normally.

## Test plan
- `0x40C0 / 0x4000` (6.0/2.0) → `done` at cycle +10, `result=0x4040`, `dz=0`. Also `0xC0C0 / 0x4000` → `0xC040`.
- `0x3F80 / 0x3FC0` (1.0/1.5) → `result=0x3F2A` (truncated 0.6640625). Also `0x3FC0 / 0x3FC0` → `0x3F80`.
- Divide by zero: `0x3F80 / 0x0000` → `0x7F80`, `dz=1`; `0xBF80 / 0x0000` → `0xFF80`, `dz=1`; `0x0000 / 0x0000` → `0x7F80`, `dz=1`. Zero dividend: `0x8000 / 0x3F80` → `0x8000`, `dz=0`.
- Range limits: `0x7F00 / 0x0080` → overflow, `0x7F80`; `0x0080 / 0x7F00` → underflow, `0x0000`.
- Handshake:
  - Pulse `start` with different operands at cycles +3 and +9 of an operation → both ignored, and the result reflects the first operands.
  - `start` held high during `done` → second operation accepted, with its `done` 11 cycles after the first.
  - Reset asserted at cycle +5 → all outputs 0 and no `done`.
- Random sweep of 10k normal operand pairs against a reference model using the same truncation, flush and saturate rules → bit-exact `result`/`dz`, fixed 10-cycle latency every time.

Source files
------------

// File: rtl/bfloat16_div_if.sv
// Start/done handshake bundle between an NPU controller and the bfloat16 divider.
interface bfloat16_div_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        dz;

    modport master (
        output start, a, b,
        input  busy, done, result, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, dz
    );
endinterface

// File: rtl/bfloat16_div.sv
// Iterative bfloat16 divider: one restoring-division quotient bit per cycle,
// fixed 10-cycle latency from the accepting edge to the done pulse.
//
// state  | meaning
// IDLE   | waiting for start; latches operand fields on acceptance
// DIV    | nine restoring-division steps, quotient q[8] down to q[0]
// NORM   | normalise, truncate, apply zero/saturate/flush cases, pulse done
module bfloat16_div (
    input  logic         clk,
    input  logic         reset,
    bfloat16_div_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [9:0]        rem_q, rem_d;
    logic [7:0]        mb_q, mb_d;
    logic [8:0]        quo_q, quo_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              za_q, za_d;
    logic              zb_q, zb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       result_q, result_d;
    logic              dz_q, dz_d;

    logic [9:0]        mb_ext;
    logic [9:0]        rem_sub;
    logic              rem_ge;
    logic signed [9:0] exp_final;
    logic [6:0]        mant_final;

    assign mb_ext  = {2'b00, mb_q};
    assign rem_ge  = (rem_q >= mb_ext);
    assign rem_sub = rem_q - mb_ext;

    // Quotient lies in 128..511; the top bit decides the one-place normalisation.
    assign exp_final  = quo_q[8] ? exp_q : (exp_q - 10'sd1);
    assign mant_final = quo_q[8] ? quo_q[7:1] : quo_q[6:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        quo_d    = quo_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        za_d     = za_q;
        zb_d     = zb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.a[15] ^ bus.b[15];
                    rem_d   = {3'b001, bus.a[6:0]};
                    mb_d    = {1'b1, bus.b[6:0]};
                    exp_d   = $signed({2'b00, bus.a[14:7]}) - $signed({2'b00, bus.b[14:7]})
                              + 10'sd127;
                    za_d    = (bus.a[14:7] == 8'h00);
                    zb_d    = (bus.b[14:7] == 8'h00);
                    quo_d   = 9'd0;
                    cnt_d   = 4'd8;
                    busy_d  = 1'b1;
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                if (rem_ge) begin
                    quo_d = {quo_q[7:0], 1'b1};
                    rem_d = {rem_sub[8:0], 1'b0};
                end else begin
                    quo_d = {quo_q[7:0], 1'b0};
                    rem_d = {rem_q[8:0], 1'b0};
                end
                if (cnt_q == 4'd0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_NORM: begin
                dz_d = 1'b0;
                if (zb_q) begin
                    result_d = {sign_q, 8'hFF, 7'h00};
                    dz_d     = 1'b1;
                end else if (za_q) begin
                    result_d = {sign_q, 15'h0000};
                end else if (exp_final >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 7'h00};
                end else if (exp_final <= 10'sd0) begin
                    result_d = {sign_q, 15'h0000};
                end else begin
                    result_d = {sign_q, exp_final[7:0], mant_final};
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rem_q    <= 10'd0;
            mb_q     <= 8'd0;
            quo_q    <= 9'd0;
            exp_q    <= 10'sd0;
            sign_q   <= 1'b0;
            za_q     <= 1'b0;
            zb_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 16'h0000;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            mb_q     <= mb_d;
            quo_q    <= quo_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            za_q     <= za_d;
            zb_q     <= zb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.dz     = dz_q;

endmodule
